// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage data-memory access unit.
// funct3 encodings, FSM states and the store byte-mask helper.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    function automatic logic [7:0] size_mask(input logic [2:0] f3);
        logic [7:0] m;
        case (f3[1:0])
            2'b00:   m = 8'h01;
            2'b01:   m = 8'h03;
            2'b10:   m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Load-data alignment and sign/zero extension.
// Shared by the MEM stage and any future cache read path.
module load_extend
    import mem_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [2:0]      offset,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] result
);

    logic [XLEN-1:0] sh;

    assign sh = rdata >> {offset, 3'b000};

    always_comb begin
        result = sh;
        case (funct3)
            F3_B:    result = {{(XLEN-8){sh[7]}}, sh[7:0]};
            F3_H:    result = {{(XLEN-16){sh[15]}}, sh[15:0]};
            F3_W:    result = {{(XLEN-32){sh[31]}}, sh[31:0]};
            F3_BU:   result = {{(XLEN-8){1'b0}}, sh[7:0]};
            F3_HU:   result = {{(XLEN-16){1'b0}}, sh[15:0]};
            F3_WU:   result = {{(XLEN-32){1'b0}}, sh[31:0]};
            default: result = sh;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: req/ack handshake, store lane
// placement and masks, load alignment/extension, pipeline stall.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int MASK_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              flush,
    input  logic              mem_re,
    input  logic              mem_we,
    input  logic [2:0]        funct3,
    input  logic [XLEN-1:0]   addr,
    input  logic [XLEN-1:0]   wdata,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [XLEN-1:0]   dmem_addr,
    output logic [XLEN-1:0]   dmem_wdata,
    output logic [MASK_W-1:0] dmem_wmask,
    input  logic              dmem_ack,
    input  logic [XLEN-1:0]   dmem_rdata,
    output logic [XLEN-1:0]   load_data,
    output logic              done,
    output logic              stall,
    output logic              err
);

    state_t          state;
    state_t          state_nx;
    logic [2:0]      off_q;
    logic [2:0]      f3_q;
    logic            load_q;
    logic            killed;
    logic            access;
    logic            misal;
    logic            illegal;
    logic            accept;
    logic            kill_now;
    logic [XLEN-1:0] ext;

    assign access = in_valid & (mem_re | mem_we) & ~flush;

    always_comb begin
        misal = 1'b0;
        case (funct3[1:0])
            2'b01:   misal = addr[0];
            2'b10:   misal = |addr[1:0];
            2'b11:   misal = |addr[2:0];
            default: misal = 1'b0;
        endcase
    end

    assign illegal = (mem_we & funct3[2])
                   | (mem_re & (funct3 == 3'b111))
                   | (mem_re & mem_we);
    assign err      = access & (misal | illegal);
    assign accept   = access & ~err;
    assign stall    = accept & (state != DONE) & ~killed;
    // A flush in the ack cycle kills the access just like an earlier one.
    assign kill_now = killed | flush;

    load_extend #(.XLEN(XLEN)) u_ext (
        .rdata  (dmem_rdata),
        .offset (off_q),
        .funct3 (f3_q),
        .result (ext)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = WAIT;
            WAIT:    if (dmem_ack) state_nx = kill_now ? IDLE : DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            dmem_wmask <= '0;
            load_data  <= '0;
            done       <= 1'b0;
            off_q      <= '0;
            f3_q       <= '0;
            load_q     <= 1'b0;
            killed     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        dmem_req  <= 1'b1;
                        dmem_we   <= mem_we;
                        dmem_addr <= {addr[XLEN-1:3], 3'b000};
                        off_q     <= addr[2:0];
                        f3_q      <= funct3;
                        load_q    <= mem_re;
                        killed    <= 1'b0;
                        if (mem_we) begin
                            dmem_wdata <= wdata << {addr[2:0], 3'b000};
                            dmem_wmask <= MASK_W'(size_mask(funct3) << addr[2:0]);
                        end else begin
                            dmem_wmask <= '0;
                        end
                    end
                end
                WAIT: begin
                    if (flush) killed <= 1'b1;
                    if (dmem_ack) begin
                        dmem_req <= 1'b0;
                        killed   <= 1'b0;
                        if (!kill_now) begin
                            done <= 1'b1;
                            if (load_q) load_data <= ext;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: vector table of single accesses
// plus flush-in-WAIT and reset-in-WAIT sequences.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        flush;
    logic        mem_re;
    logic        mem_we;
    logic [2:0]  funct3;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        dmem_req;
    logic        dmem_we;
    logic [63:0] dmem_addr;
    logic [63:0] dmem_wdata;
    logic [7:0]  dmem_wmask;
    logic        dmem_ack;
    logic [63:0] dmem_rdata;
    logic [63:0] load_data;
    logic        done;
    logic        stall;
    logic        err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .flush      (flush),
        .mem_re     (mem_re),
        .mem_we     (mem_we),
        .funct3     (funct3),
        .addr       (addr),
        .wdata      (wdata),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_wmask (dmem_wmask),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata),
        .load_data  (load_data),
        .done       (done),
        .stall      (stall),
        .err        (err)
    );

    typedef struct {
        logic        re;
        logic        we;
        logic [2:0]  f3;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
        int          dly;
        logic        err;
        logic [63:0] eaddr;
        logic [63:0] ewdata;
        logic [7:0]  emask;
        logic [63:0] eload;
    } vec_t;

    vec_t vt[16];

    function automatic vec_t mk(
        input logic re, input logic we, input logic [2:0] f3,
        input logic [63:0] a, input logic [63:0] wd,
        input logic [63:0] rd, input int dly, input logic e,
        input logic [63:0] ea, input logic [63:0] ewd,
        input logic [7:0] em, input logic [63:0] el);
        vec_t v;
        v.re = re; v.we = we; v.f3 = f3; v.addr = a;
        v.wdata = wd; v.rdata = rd; v.dly = dly; v.err = e;
        v.eaddr = ea; v.ewdata = ewd; v.emask = em; v.eload = el;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; flush = 1'b0; mem_re = 1'b0; mem_we = 1'b0;
        funct3 = 3'b0; addr = '0; wdata = '0;
        dmem_ack = 1'b0; dmem_rdata = '0;
    endtask

    task automatic do_vec(input vec_t v, input int idx);
        string t;
        t = $sformatf("v%0d", idx);
        @(posedge clk); #1;
        in_valid = 1'b1; mem_re = v.re; mem_we = v.we;
        funct3 = v.f3; addr = v.addr; wdata = v.wdata;
        #1;
        chk({t, ".err"}, 64'(err), 64'(v.err));
        chk({t, ".stall0"}, 64'(stall), 64'(!v.err));
        if (v.err) begin
            for (int k = 0; k < 3; k++) begin
                @(posedge clk); #2;
                chk({t, ".noreq"}, 64'(dmem_req), 64'd0);
                chk({t, ".nodone"}, 64'(done), 64'd0);
            end
            chk({t, ".load"}, load_data, v.eload);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #2;
        chk({t, ".req"}, 64'(dmem_req), 64'd1);
        chk({t, ".we"}, 64'(dmem_we), 64'(v.we));
        chk({t, ".addr"}, dmem_addr, v.eaddr);
        chk({t, ".mask"}, 64'(dmem_wmask), 64'(v.emask));
        if (v.we) chk({t, ".wdata"}, dmem_wdata, v.ewdata);
        chk({t, ".stallw"}, 64'(stall), 64'd1);
        for (int k = 1; k < v.dly; k++) begin
            @(posedge clk); #2;
            chk({t, ".hold"}, 64'(dmem_req), 64'd1);
            chk({t, ".holda"}, dmem_addr, v.eaddr);
            chk({t, ".stallh"}, 64'(stall), 64'd1);
        end
        dmem_ack = 1'b1;
        dmem_rdata = v.rdata;
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        dmem_rdata = 64'h5555_5555_5555_5555;
        #1;
        chk({t, ".done"}, 64'(done), 64'd1);
        chk({t, ".reqlo"}, 64'(dmem_req), 64'd0);
        chk({t, ".stalld"}, 64'(stall), 64'd0);
        chk({t, ".load"}, load_data, v.eload);
        @(posedge clk); #1;
        in_valid = 1'b0;
        #1;
        chk({t, ".pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        vt[0]  = mk(1, 0, 3'b011, 64'h1000, 0, 64'h1122334455667788, 3, 0,
                    64'h1000, 0, 8'h00, 64'h1122334455667788);
        vt[1]  = mk(1, 0, 3'b000, 64'h1007, 0, 64'h8000000000000000, 1, 0,
                    64'h1000, 0, 8'h00, 64'hFFFFFFFFFFFFFF80);
        vt[2]  = mk(1, 0, 3'b100, 64'h1007, 0, 64'h8000000000000000, 1, 0,
                    64'h1000, 0, 8'h00, 64'h80);
        vt[3]  = mk(0, 1, 3'b001, 64'h2006, 64'hABCD, 0, 1, 0,
                    64'h2000, 64'hABCD000000000000, 8'hC0, 64'h80);
        vt[4]  = mk(1, 0, 3'b010, 64'h3002, 0, 0, 1, 1,
                    0, 0, 0, 64'h80);
        vt[5]  = mk(1, 0, 3'b001, 64'h4002, 0, 64'h0000000080010000, 2, 0,
                    64'h4000, 0, 8'h00, 64'hFFFFFFFFFFFF8001);
        vt[6]  = mk(1, 0, 3'b110, 64'h4004, 0, 64'hDEADBEEF00000000, 1, 0,
                    64'h4000, 0, 8'h00, 64'h00000000DEADBEEF);
        vt[7]  = mk(1, 0, 3'b010, 64'h4004, 0, 64'hDEADBEEF00000000, 1, 0,
                    64'h4000, 0, 8'h00, 64'hFFFFFFFFDEADBEEF);
        vt[8]  = mk(0, 1, 3'b010, 64'h5004, 64'h123456789ABCDEF0, 0, 2, 0,
                    64'h5000, 64'h9ABCDEF000000000, 8'hF0,
                    64'hFFFFFFFFDEADBEEF);
        vt[9]  = mk(0, 1, 3'b000, 64'h5003, 64'h5A, 0, 1, 0,
                    64'h5000, 64'h5A000000, 8'h08, 64'hFFFFFFFFDEADBEEF);
        vt[10] = mk(0, 1, 3'b011, 64'h6004, 0, 0, 1, 1,
                    0, 0, 0, 64'hFFFFFFFFDEADBEEF);
        vt[11] = mk(0, 1, 3'b100, 64'h6000, 0, 0, 1, 1,
                    0, 0, 0, 64'hFFFFFFFFDEADBEEF);
        vt[12] = mk(1, 0, 3'b111, 64'h6000, 0, 0, 1, 1,
                    0, 0, 0, 64'hFFFFFFFFDEADBEEF);
        vt[13] = mk(1, 1, 3'b011, 64'h6000, 0, 0, 1, 1,
                    0, 0, 0, 64'hFFFFFFFFDEADBEEF);
        vt[14] = mk(1, 0, 3'b101, 64'h7006, 0, 64'hFEDC000000000000, 1, 0,
                    64'h7000, 0, 8'h00, 64'hFEDC);
        vt[15] = mk(1, 0, 3'b011, 64'h1008, 0, 64'h0123456789ABCDEF, 1, 0,
                    64'h1008, 0, 8'h00, 64'h0123456789ABCDEF);

        #12;
        chk("rst.req", 64'(dmem_req), 64'd0);
        chk("rst.we", 64'(dmem_we), 64'd0);
        chk("rst.addr", dmem_addr, 64'd0);
        chk("rst.wdata", dmem_wdata, 64'd0);
        chk("rst.mask", 64'(dmem_wmask), 64'd0);
        chk("rst.load", load_data, 64'd0);
        chk("rst.done", 64'(done), 64'd0);
        chk("rst.stall", 64'(stall), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 15; i++) do_vec(vt[i], i);

        // flush while WAIT: request completes silently
        @(posedge clk); #1;
        in_valid = 1'b1; mem_re = 1'b1; mem_we = 1'b0;
        funct3 = 3'b011; addr = 64'h1008;
        #1;
        chk("fl.stall0", 64'(stall), 64'd1);
        @(posedge clk); #1;
        flush = 1'b1;
        #1;
        chk("fl.req", 64'(dmem_req), 64'd1);
        chk("fl.stallf", 64'(stall), 64'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        #1;
        chk("fl.reqk", 64'(dmem_req), 64'd1);
        chk("fl.stallk", 64'(stall), 64'd0);
        chk("fl.nodone1", 64'(done), 64'd0);
        @(posedge clk); #1;
        dmem_ack = 1'b1;
        dmem_rdata = 64'hAAAA_AAAA_AAAA_AAAA;
        #1;
        chk("fl.stalla", 64'(stall), 64'd0);
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        #1;
        chk("fl.nodone2", 64'(done), 64'd0);
        chk("fl.reqlo", 64'(dmem_req), 64'd0);
        chk("fl.load", load_data, 64'hFEDC);
        chk("fl.idle", 64'(stall), 64'd1);
        in_valid = 1'b0;
        @(posedge clk); #2;
        chk("fl.nodone3", 64'(done), 64'd0);
        do_vec(vt[15], 15);

        // reset while WAIT: asynchronous abort
        @(posedge clk); #1;
        in_valid = 1'b1; mem_re = 1'b1; mem_we = 1'b0;
        funct3 = 3'b011; addr = 64'h2000;
        @(posedge clk); #2;
        chk("rw.req", 64'(dmem_req), 64'd1);
        rst = 1'b1;
        #1;
        chk("rw.req0", 64'(dmem_req), 64'd0);
        chk("rw.load0", load_data, 64'd0);
        chk("rw.mask0", 64'(dmem_wmask), 64'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        do_vec(mk(0, 1, 3'b011, 64'h10, 64'h0102030405060708, 0, 1, 0,
                  64'h10, 64'h0102030405060708, 8'hFF, 64'd0), 16);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage data-memory access unit of the 64-bit RV64I pipeline.
- Takes load/store requests from the EX/MEM register and runs a req/ack handshake with data memory.
- Aligns and sign/zero-extends load data, producing the `mem` operand consumed by the writeback select mux.
- Generates store byte masks, and stalls the pipeline while an access is outstanding.

Parameters:
- XLEN, 64, data/address width.
- MASK_W, 8, store byte-mask width (XLEN/8).

Ports:
- clk  input  1  pipeline clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  a valid instruction occupies MEM
- flush  input  1  squash the current MEM instruction
- mem_re  input  1  instruction is a load
- mem_we  input  1  instruction is a store
- funct3  input  3  access size/signedness
- addr  input  64  effective byte address from ALU
- wdata  input  64  store data (rs2)
- dmem_req  output  1  memory request valid
- dmem_we  output  1  request is a write
- dmem_addr  output  64  doubleword-aligned address (addr[2:0]=0)
- dmem_wdata  output  64  lane-shifted store data
- dmem_wmask  output  8  byte enables
- dmem_ack  input  1  memory completed request (rdata valid same cycle)
- dmem_rdata  input  64  raw read doubleword
- load_data  output  64  aligned, extended load result to writeback mux
- done  output  1  one-cycle pulse: access completed
- stall  output  1  hold IF..MEM pipeline registers
- err  output  1  misaligned or illegal access (combinational)

Behaviour:
- Reset, async on rst high:
  - state=IDLE.
  - dmem_req, dmem_we, done: 0.
  - dmem_addr, dmem_wdata, dmem_wmask, load_data: 0.
  - Saved offset and funct3: 0.
- access = in_valid & (mem_re | mem_we) & ~flush.
- err is combinational, =1 when access and any of:
  - LH/LHU/SH with addr[0]≠0.
  - LW/LWU/SW with addr[1:0]≠0.
  - LD/SD with addr[2:0]≠0.
  - store funct3>3, or load funct3=111.
  - mem_re&mem_we both set.
- When err=1: no request, stall=0, no done.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - On access&~err, at the clock edge:
    - dmem_req←1, dmem_we←mem_we, dmem_addr←{addr[63:3],3'b0}.
    - Register offset=addr[2:0], funct3 and the load flag.
    - For stores: dmem_wdata←wdata<<(8*offset), dmem_wmask←(size mask)<<offset, where size mask is SB=0x01, SH=0x03, SW=0x0F, SD=0xFF.
    - For loads: dmem_wmask←0.
    - Go to WAIT.
- WAIT:
  - dmem_req and all request fields are held stable until dmem_ack is sampled high.
  - On ack:
    - dmem_req←0.
    - For a load, load_data←extend(dmem_rdata>>(8*offset)), using funct3:
      - LB/LBU: sign/zero-extend 8 bits.
      - LH/LHU: sign/zero-extend 16 bits.
      - LW/LWU: sign/zero-extend 32 bits.
      - LD: 64 bits unchanged.
    - done←1; go to DONE.
  - Minimum latency: ack in the first WAIT cycle gives done two cycles after acceptance.
- DONE:
  - done=1 for exactly this cycle; the pipeline advances at this edge.
  - Unconditionally return to IDLE; a new access is accepted on the following cycle.
- stall is combinational: access & ~err & (state≠DONE). It is 0 in DONE so the instruction leaves MEM.
- flush:
  - In IDLE: suppresses acceptance.
  - In WAIT: the request cannot be retracted. The FSM still waits for ack, sets an internal killed bit, and skips the load_data update and the done pulse; stall=0 while killed. It then returns to IDLE.
  - A new access seen while killed is accepted only after return to IDLE.
- load_data holds its last completed load value; stores and errors do not modify it.
- The memory side holds dmem_ack low when dmem_req is low; an ack outside WAIT is ignored.
- rst mid-WAIT aborts immediately to the reset values. The memory side must tolerate an abandoned request.

Decomposition:
- Shared package mem_pkg:
  - funct3 constants F3_B, F3_H, F3_W, F3_D, F3_BU, F3_HU, F3_WU.
  - State enum {IDLE, WAIT, DONE}.
  - Function size_mask(funct3).
- One combinational sub-module, load_extend (rdata, offset, funct3 → 64-bit result). It is reused by any future cache path.

Test Plan:
- LD addr=0x1000, ack after 3 WAIT cycles, rdata=0x1122334455667788 → dmem_addr=0x1000, wmask=0x00; stall high 4 cycles; done pulse; load_data=0x1122334455667788.
- LB addr=0x1007, rdata=0x80xxxxxxxxxxxxxx → load_data=0xFFFFFFFFFFFFFF80. LBU at the same address → 0x0000000000000080.
- SH addr=0x2006, wdata=0xABCD, ack in first WAIT cycle → dmem_addr=0x2000, wmask=0xC0, wdata=0xABCD000000000000, dmem_we=1; load_data unchanged.
- LW addr=0x3002 → err=1, stall=0, dmem_req never asserted, no done.
- LD issued, flush asserted in WAIT, ack 2 cycles later → no done, load_data unchanged, FSM back to IDLE; the next LD is accepted normally.
- rst asserted during WAIT → dmem_req=0, state IDLE, load_data=0 asynchronously; after release, a new SD at 0x10 completes with wmask=0xFF.
